register_bus_uart: RTL and testbench

REGISTER_BUS_UART -- requirements
Module: register_bus_uart

---
 rtl/register_bus_uart_pkg.sv | 18 +
 rtl/register_bus_uart_sync_fifo.sv | 46 ++++
 rtl/register_bus_uart.sv | 255 +++++++++++++++++++++++++
 tb/tb_register_bus_uart.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/register_bus_uart_pkg.sv
// Shared definitions for register_bus_uart: register map, status bit positions and FSM states.
package register_bus_uart_pkg;

    localparam logic [11:0] IDX_TX_DATA = 12'd0;
    localparam logic [11:0] IDX_STATUS  = 12'd1;
    localparam logic [11:0] IDX_RX_DATA = 12'd2;
    localparam logic [11:0] IDX_DIVISOR = 12'd3;
    localparam logic [11:0] IDX_HALT    = 12'd4095;

    localparam int STAT_FULL     = 0;
    localparam int STAT_BUSY     = 1;
    localparam int STAT_RX_VALID = 2;
    localparam int STAT_OVERRUN  = 3;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/register_bus_uart_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a push while full is accepted only alongside a pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout    = mem[rd_ptr[AW-1:0]];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage needs no reset; the pointers alone define valid contents.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/register_bus_uart.sv
// Register-mapped 8N1 UART: bus writes feed a TX FIFO and serial shifter.
// Define UART_RX_EN to include the receiver and its uart_rx port.
module register_bus_uart
    import register_bus_uart_pkg::*;
#(
    parameter logic [15:0] DIV_RESET  = 16'd434,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] register_index,
    input  logic        register_read,
    input  logic        register_write,
    input  logic [15:0] register_write_value,
    output logic [15:0] register_read_value,
    output logic        uart_tx,
`ifdef UART_RX_EN
    input  logic        uart_rx,
`endif
    output logic        halted
);

    logic        wr_tx;
    logic        wr_div;
    logic        wr_halt;
    logic        rd_status;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_dout;
    logic [15:0] divisor;
    logic        overrun;
    logic        tx_busy;
    logic        rx_valid;
    logic        rx_overrun;
    logic [7:0]  rx_data;
    logic [15:0] status_word;
    logic [15:0] read_mux;

    tx_state_t   tx_state,  tx_state_n;
    logic [7:0]  tx_shift,  tx_shift_n;
    logic [2:0]  tx_bit,    tx_bit_n;
    logic [15:0] tx_timer,  tx_timer_n;
    logic        tx_line,   tx_line_n;

    assign wr_tx     = register_write && (register_index == IDX_TX_DATA);
    assign wr_div    = register_write && (register_index == IDX_DIVISOR);
    assign wr_halt   = register_write && (register_index == IDX_HALT);
    assign rd_status = register_read  && (register_index == IDX_STATUS);
    assign tx_busy   = !fifo_empty || (tx_state != TX_IDLE);
    assign uart_tx   = tx_line;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_tx),
        .pop   (fifo_pop),
        .din   (register_write_value[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        status_word                = '0;
        status_word[STAT_FULL]     = fifo_full;
        status_word[STAT_BUSY]     = tx_busy;
        status_word[STAT_RX_VALID] = rx_valid;
        status_word[STAT_OVERRUN]  = overrun;
    end

    always_comb begin
        read_mux = '0;
        case (register_index)
            IDX_STATUS:  read_mux = status_word;
            IDX_RX_DATA: read_mux = {8'h00, rx_data};
            IDX_DIVISOR: read_mux = divisor;
            default:     read_mux = '0;
        endcase
    end

    // A new overrun event wins over the clear-on-read of the status register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            divisor             <= DIV_RESET;
            halted              <= 1'b0;
            overrun             <= 1'b0;
            register_read_value <= '0;
        end else begin
            if (wr_div)        divisor <= (register_write_value == 16'd0) ? 16'd1 : register_write_value;
            if (wr_halt)       halted  <= 1'b1;
            overrun <= (overrun && !rd_status) || (wr_tx && fifo_full && !fifo_pop) || rx_overrun;
            if (register_read) register_read_value <= read_mux;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state <= TX_IDLE;
            tx_shift <= '0;
            tx_bit   <= '0;
            tx_timer <= '0;
            tx_line  <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_shift <= tx_shift_n;
            tx_bit   <= tx_bit_n;
            tx_timer <= tx_timer_n;
            tx_line  <= tx_line_n;
        end
    end

    // The timer reloads from the live divisor at every bit boundary.
    always_comb begin
        tx_state_n = tx_state;
        tx_shift_n = tx_shift;
        tx_bit_n   = tx_bit;
        tx_timer_n = (tx_timer != 16'd0) ? tx_timer - 16'd1 : 16'd0;
        tx_line_n  = tx_line;
        fifo_pop   = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                tx_line_n = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    tx_state_n = TX_START;
                    tx_shift_n = fifo_dout;
                    tx_timer_n = divisor - 16'd1;
                    tx_line_n  = 1'b0;
                end
            end
            TX_START: begin
                if (tx_timer == 16'd0) begin
                    tx_state_n = TX_DATA;
                    tx_bit_n   = 3'd0;
                    tx_timer_n = divisor - 16'd1;
                    tx_line_n  = tx_shift[0];
                end
            end
            TX_DATA: begin
                if (tx_timer == 16'd0) begin
                    tx_timer_n = divisor - 16'd1;
                    if (tx_bit == 3'd7) begin
                        tx_state_n = TX_STOP;
                        tx_line_n  = 1'b1;
                    end else begin
                        tx_bit_n   = tx_bit + 3'd1;
                        tx_shift_n = tx_shift >> 1;
                        tx_line_n  = tx_shift[1];
                    end
                end
            end
            TX_STOP: begin
                if (tx_timer == 16'd0) begin
                    tx_state_n = TX_IDLE;
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
    end

`ifdef UART_RX_EN
    logic        rd_rx;
    logic        rx_sync1;
    logic        rx_sync2;
    logic        rx_prev;
    logic        rx_load;
    rx_state_t   rx_state,  rx_state_n;
    logic [15:0] rx_timer,  rx_timer_n;
    logic [2:0]  rx_bit,    rx_bit_n;
    logic [7:0]  rx_shift,  rx_shift_n;

    assign rd_rx      = register_read && (register_index == IDX_RX_DATA);
    assign rx_overrun = rx_load && rx_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_sync1 <= 1'b1;
            rx_sync2 <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_timer <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_sync1 <= uart_rx;
            rx_sync2 <= rx_sync1;
            rx_prev  <= rx_sync2;
            rx_state <= rx_state_n;
            rx_timer <= rx_timer_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
            if (rx_load) begin
                rx_data  <= rx_shift;
                rx_valid <= 1'b1;
            end else if (rd_rx) begin
                rx_valid <= 1'b0;
            end
        end
    end

    // Half a bit after the falling edge lands mid-start; later samples are a full bit apart.
    always_comb begin
        rx_state_n = rx_state;
        rx_timer_n = (rx_timer != 16'd0) ? rx_timer - 16'd1 : 16'd0;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_load    = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rx_prev && !rx_sync2) begin
                    rx_state_n = RX_START;
                    rx_timer_n = divisor >> 1;
                end
            end
            RX_START: begin
                if (rx_timer == 16'd0) begin
                    if (!rx_sync2) begin
                        rx_state_n = RX_DATA;
                        rx_bit_n   = 3'd0;
                        rx_timer_n = divisor - 16'd1;
                    end else begin
                        rx_state_n = RX_IDLE;
                    end
                end
            end
            RX_DATA: begin
                if (rx_timer == 16'd0) begin
                    rx_shift_n = {rx_sync2, rx_shift[7:1]};
                    rx_timer_n = divisor - 16'd1;
                    if (rx_bit == 3'd7) rx_state_n = RX_STOP;
                    else                rx_bit_n   = rx_bit + 3'd1;
                end
            end
            RX_STOP: begin
                if (rx_timer == 16'd0) begin
                    rx_state_n = RX_IDLE;
                    rx_load    = rx_sync2;
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end
`else
    assign rx_valid   = 1'b0;
    assign rx_data    = 8'h00;
    assign rx_overrun = 1'b0;
`endif

endmodule

// File: tb/tb_register_bus_uart.sv
// Scoreboard bench for register_bus_uart: expected reads and TX bytes are queued by the
// stimulus thread and popped by independent monitors. Receiver tests build under UART_RX_EN.
module tb_register_bus_uart;

    localparam logic [15:0] DIV_RESET  = 16'd434;
    localparam int          FIFO_DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] register_index;
    logic        register_read;
    logic        register_write;
    logic [15:0] register_write_value;
    logic [15:0] register_read_value;
    logic        uart_tx;
    logic        halted;
`ifdef UART_RX_EN
    logic        uart_rx;
`endif

    int checks = 0;
    int errors = 0;
    int cur_div;

    string       rd_name_q[$];
    logic [15:0] rd_exp_q[$];
    logic [7:0]  tx_exp_q[$];

    always #5 clk = ~clk;

    register_bus_uart #(
        .DIV_RESET  (DIV_RESET),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .register_index       (register_index),
        .register_read        (register_read),
        .register_write       (register_write),
        .register_write_value (register_write_value),
        .register_read_value  (register_read_value),
        .uart_tx              (uart_tx),
`ifdef UART_RX_EN
        .uart_rx              (uart_rx),
`endif
        .halted               (halted)
    );

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic bus_write(input logic [11:0] idx, input logic [15:0] val);
        register_index       = idx;
        register_write_value = val;
        register_write       = 1'b1;
        @(negedge clk);
        register_write       = 1'b0;
    endtask

    task automatic bus_read(input string name, input logic [11:0] idx, input logic [15:0] expected);
        rd_name_q.push_back(name);
        rd_exp_q.push_back(expected);
        register_index = idx;
        register_read  = 1'b1;
        @(negedge clk);
        register_read  = 1'b0;
    endtask

    task automatic bus_rw(input string name, input logic [11:0] idx, input logic [15:0] val,
                          input logic [15:0] expected);
        rd_name_q.push_back(name);
        rd_exp_q.push_back(expected);
        register_index       = idx;
        register_write_value = val;
        register_read        = 1'b1;
        register_write       = 1'b1;
        @(negedge clk);
        register_read        = 1'b0;
        register_write       = 1'b0;
    endtask

    task automatic set_divisor(input int div);
        bus_write(12'd3, 16'(div));
        cur_div = (div == 0) ? 1 : div;
        bus_read("divisor_readback", 12'd3, 16'(cur_div));
    endtask

    task automatic send_byte(input logic [7:0] b);
        tx_exp_q.push_back(b);
        bus_write(12'd0, {8'h00, b});
    endtask

    task automatic wait_tx_drain(input int budget);
        int n = 0;
        while (tx_exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_output("tx_drain", 64'(tx_exp_q.size()), 64'd0);
        repeat (cur_div + 3) @(negedge clk);
    endtask

    task automatic skip_cycles(input int n, inout logic ok);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (reset !== 1'b1) ok = 1'b0;
        end
    endtask

`ifdef UART_RX_EN
    task automatic rx_send(input logic [7:0] b, input int div);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = f[i];
            repeat (div) @(negedge clk);
        end
    endtask
`endif

    // Read monitor: every sampled read strobe yields a value one edge later.
    initial begin : read_monitor
        string       name;
        logic [15:0] expected;
        forever begin
            @(posedge clk);
            if (reset === 1'b1 && register_read === 1'b1) begin
                @(negedge clk);
                if (rd_exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL read_unexpected: got %0h, expected no read", register_read_value);
                end else begin
                    name     = rd_name_q.pop_front();
                    expected = rd_exp_q.pop_front();
                    check_output(name, 64'(register_read_value), 64'(expected));
                end
            end
        end
    end

    // TX monitor: decodes 8N1 frames at mid-bit using the bench's divisor model.
    initial begin : tx_monitor
        logic       prev;
        logic       ok;
        logic [9:0] frame;
        logic [7:0] expected;
        int         div;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                prev = 1'b1;
            end else if (prev && !uart_tx) begin
                div = cur_div;
                ok  = 1'b1;
                skip_cycles(div / 2, ok);
                frame[0] = uart_tx;
                for (int i = 1; i < 10; i++) begin
                    skip_cycles(div, ok);
                    frame[i] = uart_tx;
                end
                if (ok) begin
                    if (tx_exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL tx_unexpected: got frame %0h, expected none", frame);
                    end else begin
                        expected = tx_exp_q.pop_front();
                        check_output("tx_frame", 64'(frame), 64'({1'b1, expected, 1'b0}));
                    end
                end
                prev = 1'b1;
            end else begin
                prev = uart_tx;
            end
        end
    end

    initial begin : watchdog
        repeat (200000) @(posedge clk);
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : apply_stimulus
        logic [40:0] wave;
        logic [40:0] exp_wave;
        logic [9:0]  fr;
        logic [7:0]  b;
        int          div;
        int          n;

        reset                = 1'b0;
        register_index       = '0;
        register_read        = 1'b0;
        register_write       = 1'b0;
        register_write_value = '0;
        cur_div              = int'(DIV_RESET);
`ifdef UART_RX_EN
        uart_rx              = 1'b1;
`endif
        repeat (3) @(negedge clk);
        check_output("reset_uart_tx", 64'(uart_tx), 64'd1);
        check_output("reset_halted", 64'(halted), 64'd0);
        check_output("reset_read_value", 64'(register_read_value), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        bus_read("reset_divisor", 12'd3, DIV_RESET);
        bus_read("reset_status", 12'd1, 16'h0000);
        bus_read("read_tx_index", 12'd0, 16'h0000);
        bus_read("reset_rx_data", 12'd2, 16'h0000);

        set_divisor(0);
        set_divisor(4);

        // Frame 0x41 at divisor 4, sampled every clock from the write edge onward.
        fr = {1'b1, 8'h41, 1'b0};
        send_byte(8'h41);
        wave[0]     = uart_tx;
        exp_wave[0] = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            wave[k]     = uart_tx;
            exp_wave[k] = fr[(k - 1) / 4];
        end
        check_output("tx_waveform_0x41", 64'(wave), 64'(exp_wave));
        repeat (2) @(negedge clk);
        bus_read("status_after_frame", 12'd1, 16'h0000);

        bus_write(12'd4095, 16'h0001);
        check_output("halted_set", 64'(halted), 64'd1);
        repeat (20) @(negedge clk);
        check_output("halted_sticky", 64'(halted), 64'd1);

        // Overflow: one byte in flight, eight fill the FIFO, the ninth is dropped.
        set_divisor(20);
        send_byte(8'($urandom));
        @(negedge clk);
        for (int i = 0; i < FIFO_DEPTH; i++) send_byte(8'($urandom));
        bus_read("status_full", 12'd1, 16'h0003);
        bus_write(12'd0, 16'h00EE);
        bus_read("status_overrun", 12'd1, 16'h000B);
        bus_read("status_overrun_cleared", 12'd1, 16'h0003);
        wait_tx_drain(3000);
        bus_read("status_drained", 12'd1, 16'h0000);

        bus_rw("rw_same_cycle_old", 12'd3, 16'd7, 16'd20);
        bus_read("rw_same_cycle_new", 12'd3, 16'd7);
        cur_div = 7;

        for (int r = 0; r < 5; r++) begin
            div = $urandom_range(2, 12);
            set_divisor(div);
            bus_write(12'($urandom_range(4, 4094)), 16'($urandom));
            bus_read("divisor_after_ignored_write", 12'd3, 16'(div));
            bus_read("unmapped_read", 12'($urandom_range(4, 4094)), 16'h0000);
            n = $urandom_range(1, FIFO_DEPTH);
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                send_byte(b);
            end
            wait_tx_drain(n * (10 * div + 2) + 100);
            bus_read("status_random_idle", 12'd1, 16'h0000);
        end

`ifdef UART_RX_EN
        set_divisor(8);
        rx_send(8'h5A, 8);
        repeat (4) @(negedge clk);
        bus_read("rx_status_valid", 12'd1, 16'h0004);
        bus_read("rx_data_5a", 12'd2, 16'h005A);
        bus_read("rx_status_cleared", 12'd1, 16'h0000);
        rx_send(8'h33, 8);
        rx_send(8'hC4, 8);
        repeat (4) @(negedge clk);
        bus_read("rx_status_overrun", 12'd1, 16'h000C);
        bus_read("rx_data_overwritten", 12'd2, 16'h00C4);
        bus_read("rx_status_final", 12'd1, 16'h0000);
`endif

        // Reset during data bit 0 of 0x96 (a low bit) with a second byte still queued.
        set_divisor(4);
        bus_write(12'd0, 16'h0096);
        bus_write(12'd0, 16'h003C);
        repeat (5) @(negedge clk);
        check_output("tx_low_before_reset", 64'(uart_tx), 64'd0);
        check_output("halted_until_reset", 64'(halted), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check_output("tx_async_reset", 64'(uart_tx), 64'd1);
        @(negedge clk);
        check_output("halted_in_reset", 64'(halted), 64'd0);
        check_output("read_value_in_reset", 64'(register_read_value), 64'd0);
        reset   = 1'b1;
        cur_div = int'(DIV_RESET);
        @(negedge clk);
        bus_read("status_after_reset", 12'd1, 16'h0000);
        bus_read("divisor_after_reset", 12'd3, DIV_RESET);
        repeat (50) @(negedge clk);
        check_output("halted_after_reset", 64'(halted), 64'd0);
        check_output("reads_all_answered", 64'(rd_exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
